// File: rtl/store_aligner.sv
// store_aligner: splits byte/half/word stores into word-aligned write beats.
// Ports: req_* store request, mem_* aligned beat out, misaligned, done pulse.
module store_aligner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sb,
  input  logic        sh,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        misaligned,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        sb_q;
  logic        sh_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        done_q;
  logic        last_hs;
  logic        accept;

  logic [3:0]  mask;
  logic [31:0] lane_mask;
  logic [31:0] data_m;
  logic [4:0]  shamt;
  logic [63:0] wide_data;
  logic [7:0]  wide_strb;
  logic        split;
  logic [31:0] base;
  logic [31:0] next;

  assign accept = req_valid && (state_q == IDLE);

  // Both strobes high falls through to a word store.
  always_comb begin
    mask = 4'b1111;
    unique case (1'b1)
      (sb_q && !sh_q): mask = 4'b0001;
      (sh_q && !sb_q): mask = 4'b0011;
      default:         mask = 4'b1111;
    endcase
  end

  // Clear bytes above the store size so unused lanes drive zero.
  assign lane_mask = {{8{mask[3]}}, {8{mask[2]}},
                      {8{mask[1]}}, {8{mask[0]}}};
  assign data_m    = data_q & lane_mask;
  assign shamt     = {addr_q[1:0], 3'b000};
  assign wide_data = {32'h0, data_m} << shamt;
  assign wide_strb = {4'h0, mask} << addr_q[1:0];
  assign split     = |wide_strb[7:4];
  assign base      = {addr_q[31:2], 2'b00};
  assign next      = base + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_hs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q   <= 1'b0;
      sh_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      sb_q   <= sb;
      sh_q   <= sh;
      addr_q <= addr_in;
      data_q <= data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    last_hs = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) state_d = BEAT0;
      end
      BEAT0: begin
        if (mem_ready) begin
          state_d = split ? BEAT1 : IDLE;
          last_hs = !split;
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d = IDLE;
          last_hs = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    misaligned = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      BEAT0: begin
        mem_valid  = 1'b1;
        mem_addr   = base;
        mem_wdata  = wide_data[31:0];
        mem_wstrb  = wide_strb[3:0];
        misaligned = split;
      end
      BEAT1: begin
        mem_valid  = 1'b1;
        mem_addr   = next;
        mem_wdata  = wide_data[63:32];
        mem_wstrb  = wide_strb[7:4];
        misaligned = split;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign done = done_q;

endmodule

// File: doc/store_aligner.md
# store_aligner

Store-path counterpart of the load modifier. Accepts a byte, halfword or word store with an arbitrary byte address and issues word-aligned write beats with byte strobes to the data-memory port. Stores that cross a 32-bit word boundary are split into two beats. The block sits between the execute-stage store request and the data-memory write interface.

## Interface
Parameters:
- None. Data is fixed at 32 bits and addresses are fixed at 32 bits.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sb`  in  1  byte store. If both `sb` and `sh` are high, the store is treated as a word store.
- `sh`  in  1  halfword store. If `sb` and `sh` are both low, the store is a word store.
- `req_valid`  in  1  store request valid.
- `req_ready`  out  1  block can accept a request.
- `addr_in`  in  32  byte address of the store.
- `data_in`  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- `mem_valid`  out  1  write beat valid.
- `mem_ready`  in  1  memory accepts the beat.
- `mem_addr`  out  32  word-aligned beat address; bits [1:0] are always 0.
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_wstrb`  out  4  byte strobes; bit i enables byte lane i (bits [8i+7:8i]).
- `misaligned`  out  1  the current request needs two beats; valid while `mem_valid` is high.
- `done`  out  1  one-cycle pulse when a store has fully completed.

## Operation
- Handshakes:
  - A request is accepted on a rising edge where `req_valid` and `req_ready` are both high.
  - On acceptance, `sb`, `sh`, `addr_in` and `data_in` are registered.
- Size mask: byte = 4'b0001, halfword = 4'b0011, word = 4'b1111.
- Alignment arithmetic, with `off = addr[1:0]`:
  - `wide_data` (64 bits) = {32'b0, data} << (8·off).
  - `wide_strb` (8 bits) = {4'b0, mask} << off.
- Beat 0:
  - address = {addr[31:2], 2'b00}
  - data = `wide_data`[31:0]
  - strobes = `wide_strb`[3:0]
- Beat 1:
  - Required if and only if `wide_strb`[7:4] ≠ 0. This is the case for a halfword at off 3 and for a word at off 1, 2 or 3.
  - address = beat 0 address + 4, computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - data = `wide_data`[63:32]
  - strobes = `wide_strb`[7:4]
- Bytes not enabled by the strobes are driven 0 in `mem_wdata`.
- State machine:
  - `IDLE`: `req_ready` = 1 and `mem_valid` = 0. An accepted request moves to `BEAT0`.
  - `BEAT0`: `mem_valid` = 1 and beat 0 is driven. When `mem_ready` is high, go to `BEAT1` if `misaligned`, otherwise go to `IDLE`.
  - `BEAT1`: `mem_valid` = 1 and beat 1 is driven. When `mem_ready` is high, go to `IDLE`.
- `done` is registered. It is high for exactly one cycle, the cycle after the final beat's handshake.
- `req_ready` is low in `BEAT0` and `BEAT1`. No request queuing.
- While `mem_valid` is low, `mem_addr`, `mem_wdata`, `mem_wstrb` and `misaligned` are driven 0.

## Timing
- Reset values:
  - state `IDLE`
  - `req_ready` = 1
  - `mem_valid` = 0
  - `mem_addr` = 0
  - `mem_wdata` = 0
  - `mem_wstrb` = 0
  - `misaligned` = 0
  - `done` = 0
- Latency:
  - Accept at edge N gives `mem_valid` high in cycle N+1.
  - With `mem_ready` tied high, an aligned store handshakes at edge N+1 and `done` is high in cycle N+2. A split store handshakes at N+1 and N+2, and `done` is high in N+3.
- Throughput: a new request may be accepted in the same cycle `done` is high (back-to-back). Peak rate is one aligned store per 2 cycles.
- Backpressure: while `mem_valid` is high and `mem_ready` is low, `mem_addr`, `mem_wdata`, `mem_wstrb` and `misaligned` hold stable. Input changes after acceptance have no effect.
- `mem_ready` high while `mem_valid` is low is ignored.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronous). The store is abandoned with no `done` pulse and no further beats.

## Test plan
- **Aligned word:** word store, addr 0x00001000, data 0xDEADBEEF, `mem_ready` = 1.
  - One beat: addr 0x00001000, wdata 0xDEADBEEF, wstrb 4'b1111, `misaligned` 0.
  - `done` pulses 2 cycles after accept.
- **Byte, top lane:** sb, addr 0x00002003, data 0x000000A5.
  - One beat: addr 0x00002000, wdata 0xA5000000, wstrb 4'b1000.
- **Split halfword:** sh, addr 0x00003003, data 0x00001234.
  - Beat 0: addr 0x00003000, wdata 0x34000000, wstrb 4'b1000, `misaligned` 1.
  - Beat 1: addr 0x00003004, wdata 0x00000012, wstrb 4'b0001.
  - Exactly one `done` pulse.
- **Split word with backpressure:** word store, addr 0x00004002, data 0x11223344, `mem_ready` low for 3 cycles in each beat.
  - Beat 0: addr 0x00004000, wdata 0x33440000, wstrb 4'b1100, held stable.
  - Beat 1: addr 0x00004004, wdata 0x00001122, wstrb 4'b0011.
  - `req_ready` stays low throughout.
- **Address wrap:** word store, addr 0xFFFFFFFD, data 0xAABBCCDD.
  - Beat 0: addr 0xFFFFFFFC, wdata 0xBBCCDD00, wstrb 4'b1110.
  - Beat 1: addr 0x00000000, wdata 0x000000AA, wstrb 4'b0001.
- **Reset mid-split:** assert `rst_n` low during beat 1 of the split-halfword case.
  - All outputs return to reset values with no `done` pulse.
  - After release, an aligned word store completes normally.
